// File: rtl/vproc_pkg.sv
// Shared definitions for the XIF memory responder: exception codes, the
// request-size encoding and small address-decode helpers.
package vproc_pkg;

  localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
  localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
  localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
  localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } mem_size_e;

  // Size 3 has no legal alignment, so it always reports misaligned.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = a[0];
      SIZE_WORD: is_misaligned = |a;
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: byte_en = 4'b0001 << a;
      SIZE_HALF: byte_en = 4'b0011 << a;
      SIZE_WORD: byte_en = 4'b1111;
      default:   byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/vproc_id_fifo.sv
// Small synchronous FIFO holding IDs of requests forwarded to the bus and
// still waiting for their response.
module vproc_id_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             async_rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);
  // A pop never frees a slot for a push in the same cycle.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    !(pop_i && empty_o));

endmodule

// File: rtl/vproc_xif_mem_responder.sv
// Host-side XIF memory responder: checks alignment and address window,
// forwards legal requests to an OBI-style bus and returns in-order results.
module vproc_xif_mem_responder
  import vproc_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH      = 3,
  parameter int unsigned X_MEM_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] MEM_BASE        = 32'h0,
  parameter logic [31:0] MEM_SIZE        = 32'h8000_0000
) (
  input  logic                     clk_i,
  input  logic                     async_rst_ni,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [X_ID_WIDTH-1:0]    mem_req_id_i,
  input  logic [31:0]              mem_req_addr_i,
  input  logic                     mem_req_we_i,
  input  logic [1:0]               mem_req_size_i,
  input  logic [X_MEM_WIDTH-1:0]   mem_req_wdata_i,
  input  logic                     mem_req_spec_i,
  output logic                     mem_resp_exc_o,
  output logic [5:0]               mem_resp_exccode_o,
  output logic                     mem_resp_dbg_o,
  output logic                     mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0]    mem_result_id_o,
  output logic [X_MEM_WIDTH-1:0]   mem_result_rdata_o,
  output logic                     mem_result_err_o,
  output logic                     mem_result_dbg_o,
  output logic                     data_req_o,
  input  logic                     data_gnt_i,
  output logic [31:0]              data_addr_o,
  output logic                     data_we_o,
  output logic [X_MEM_WIDTH/8-1:0] data_be_o,
  output logic [X_MEM_WIDTH-1:0]   data_wdata_o,
  input  logic                     data_rvalid_i,
  input  logic [X_MEM_WIDTH-1:0]   data_rdata_i,
  input  logic                     data_err_i
);

  mem_size_e       w_size;
  logic [1:0]      w_a;
  logic [32:0]     w_addr33, w_lim33;
  logic            w_misalign, w_fault, w_exc;
  logic            w_full, w_empty, w_push, w_pop;
  logic [X_ID_WIDTH-1:0] w_head_id;
  logic            w_unused;

  // Speculation hint is irrelevant: every request is executed as final.
  assign w_unused = mem_req_spec_i;

  assign w_size     = mem_size_e'(mem_req_size_i);
  assign w_a        = mem_req_addr_i[1:0];
  assign w_addr33   = {1'b0, mem_req_addr_i};
  assign w_lim33    = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
  assign w_misalign = is_misaligned(w_size, w_a);
  assign w_fault    = (w_addr33 < {1'b0, MEM_BASE}) || (w_addr33 >= w_lim33);
  assign w_exc      = w_misalign || w_fault;

  always_comb begin
    mem_resp_exccode_o = 6'd0;
    if (w_misalign)   mem_resp_exccode_o = mem_req_we_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
    else if (w_fault) mem_resp_exccode_o = mem_req_we_i ? EXC_ST_FAULT    : EXC_LD_FAULT;
  end

  // Excepting requests are acked immediately and never reach the bus.
  assign data_req_o     = mem_valid_i && !w_exc && !w_full;
  assign w_push         = data_req_o && data_gnt_i;
  assign mem_ready_o    = (mem_valid_i && w_exc) || w_push;
  assign mem_resp_exc_o = mem_valid_i && w_exc;
  assign mem_resp_dbg_o = 1'b0;

  assign data_addr_o  = {mem_req_addr_i[31:2], 2'b00};
  assign data_we_o    = mem_req_we_i;
  assign data_be_o    = byte_en(w_size, w_a);
  assign data_wdata_o = mem_req_wdata_i << {w_a, 3'b000};

  assign w_pop              = data_rvalid_i;
  assign mem_result_valid_o = data_rvalid_i && !w_empty;
  assign mem_result_id_o    = w_head_id;
  assign mem_result_rdata_o = data_rdata_i;
  assign mem_result_err_o   = data_err_i;
  assign mem_result_dbg_o   = 1'b0;

  vproc_id_fifo #(
    .WIDTH (X_ID_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i        (clk_i),
    .async_rst_ni (async_rst_ni),
    .push_i       (w_push),
    .data_i       (mem_req_id_i),
    .pop_i        (w_pop),
    .data_o       (w_head_id),
    .full_o       (w_full),
    .empty_o      (w_empty)
  );

  a_ready_cause: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    mem_ready_o |-> (data_gnt_i || mem_resp_exc_o));

endmodule

// File: tb/tb_vproc_xif_mem_responder.sv
// Directed bench for vproc_xif_mem_responder: one task per scenario.
module tb_vproc_xif_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_ready, mem_we, mem_spec;
  logic [2:0]  mem_id;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        resp_exc, resp_dbg;
  logic [5:0]  resp_code;
  logic        res_valid, res_err, res_dbg;
  logic [2:0]  res_id;
  logic [31:0] res_rdata;
  logic        d_req, d_gnt, d_we, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vproc_xif_mem_responder #(
    .X_ID_WIDTH(3), .X_MEM_WIDTH(32), .MAX_OUTSTANDING(2),
    .MEM_BASE(32'h0), .MEM_SIZE(32'h8000_0000)
  ) dut (
    .clk_i(clk), .async_rst_ni(rst_n),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_req_id_i(mem_id),
    .mem_req_addr_i(mem_addr), .mem_req_we_i(mem_we), .mem_req_size_i(mem_size),
    .mem_req_wdata_i(mem_wdata), .mem_req_spec_i(mem_spec),
    .mem_resp_exc_o(resp_exc), .mem_resp_exccode_o(resp_code), .mem_resp_dbg_o(resp_dbg),
    .mem_result_valid_o(res_valid), .mem_result_id_o(res_id),
    .mem_result_rdata_o(res_rdata), .mem_result_err_o(res_err), .mem_result_dbg_o(res_dbg),
    .data_req_o(d_req), .data_gnt_i(d_gnt), .data_addr_o(d_addr), .data_we_o(d_we),
    .data_be_o(d_be), .data_wdata_o(d_wdata),
    .data_rvalid_i(d_rvalid), .data_rdata_i(d_rdata), .data_err_i(d_err)
  );

  task automatic drv(input logic v, input logic [2:0] id, input logic [31:0] addr,
                     input logic we, input logic [1:0] sz, input logic [31:0] wd);
    mem_valid = v; mem_id = id; mem_addr = addr; mem_we = we; mem_size = sz; mem_wdata = wd;
  endtask

  task automatic bus(input logic gnt, input logic rv, input logic [31:0] rd, input logic err);
    d_gnt = gnt; d_rvalid = rv; d_rdata = rd; d_err = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_spec = 1'b1;
    drv(0, 0, 0, 0, 0, 0); bus(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({d_req, mem_ready, res_valid, resp_dbg, res_dbg} !== 5'b0) begin
      failures++; $display("FAIL reset_idle got %b exp 00000", {d_req, mem_ready, res_valid, resp_dbg, res_dbg});
    end
  endtask

  task automatic test_word_load();
    @(negedge clk); drv(1, 5, 32'h100, 0, 2, 0); bus(0, 0, 0, 0); #1;
    checks++;
    if ({d_req, mem_ready} !== 2'b10) begin
      failures++; $display("FAIL ld_no_gnt req/ready got %b exp 10", {d_req, mem_ready});
    end
    d_gnt = 1'b1; #1;
    checks++;
    if ({mem_ready, resp_exc, d_req, d_we} !== 4'b1010) begin
      failures++; $display("FAIL ld_accept ready/exc/req/we got %b exp 1010", {mem_ready, resp_exc, d_req, d_we});
    end
    checks++;
    if (d_be !== 4'b1111 || d_addr !== 32'h100) begin
      failures++; $display("FAIL ld_bus be=%b addr=%h exp be=1111 addr=00000100", d_be, d_addr);
    end
    @(negedge clk); drv(0, 0, 0, 0, 0, 0); bus(0, 0, 0, 0); #1;
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL ld_early_result got %b exp 0", res_valid);
    end
    repeat (2) @(negedge clk);
    bus(0, 1, 32'hDEADBEEF, 0); #1;
    checks++;
    if ({res_valid, res_id, res_rdata, res_err} !== {1'b1, 3'd5, 32'hDEADBEEF, 1'b0}) begin
      failures++; $display("FAIL ld_result v=%b id=%0d rdata=%h err=%b exp v=1 id=5 rdata=deadbeef err=0",
                           res_valid, res_id, res_rdata, res_err);
    end
    @(negedge clk); bus(0, 0, 0, 0);
  endtask

  task automatic test_byte_store();
    @(negedge clk); drv(1, 1, 32'h103, 1, 0, 32'hAB); bus(1, 0, 0, 0); #1;
    checks++;
    if (d_be !== 4'b1000 || d_wdata !== 32'hAB00_0000 || d_addr !== 32'h100) begin
      failures++; $display("FAIL st_byte be=%b wdata=%h addr=%h exp be=1000 wdata=ab000000 addr=00000100",
                           d_be, d_wdata, d_addr);
    end
    checks++;
    if ({mem_ready, resp_exc, d_we} !== 3'b101) begin
      failures++; $display("FAIL st_byte_accept ready/exc/we got %b exp 101", {mem_ready, resp_exc, d_we});
    end
    @(negedge clk); drv(0, 0, 0, 0, 0, 0); bus(0, 1, 0, 0); #1;
    checks++;
    if ({res_valid, res_id} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL st_result v=%b id=%0d exp v=1 id=1", res_valid, res_id);
    end
    @(negedge clk); bus(0, 0, 0, 0);
  endtask

  task automatic test_exceptions();
    logic [31:0] ta [5];
    logic        tw [5];
    logic [1:0]  ts [5];
    logic [5:0]  tc [5];
    ta = '{32'h101, 32'h8000_0000, 32'h200, 32'h8000_0001, 32'h9000_0000};
    tw = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ts = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
    tc = '{6'd4, 6'd7, 6'd6, 6'd4, 6'd5};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drv(1, 3'(i), ta[i], tw[i], ts[i], 0); bus(1, 0, 0, 0); #1;
      checks++;
      if ({mem_ready, resp_exc, d_req, res_valid} !== 4'b1100 || resp_code !== tc[i]) begin
        failures++; $display("FAIL exc_%0d ready/exc/req/rv=%b code=%0d exp 1100 code=%0d",
                             i, {mem_ready, resp_exc, d_req, res_valid}, resp_code, tc[i]);
      end
    end
    // Last byte of the window is legal.
    @(negedge clk); drv(1, 2, 32'h7FFF_FFFF, 0, 0, 0); bus(1, 0, 0, 0); #1;
    checks++;
    if ({mem_ready, resp_exc, d_req} !== 3'b101 || d_be !== 4'b1000) begin
      failures++; $display("FAIL edge_legal ready/exc/req=%b be=%b exp 101 be=1000",
                           {mem_ready, resp_exc, d_req}, d_be);
    end
    @(negedge clk); drv(0, 0, 0, 0, 0, 0); bus(0, 1, 32'h5A, 0); #1;
    checks++;
    if ({res_valid, res_id} !== {1'b1, 3'd2}) begin
      failures++; $display("FAIL edge_result v=%b id=%0d exp v=1 id=2", res_valid, res_id);
    end
    @(negedge clk); bus(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drv(1, 1, 32'h10, 0, 2, 0); bus(1, 0, 0, 0); #1;
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL b2b_id1 ready got %b exp 1", mem_ready); end
    @(negedge clk); drv(1, 2, 32'h14, 0, 2, 0); #1;
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL b2b_id2 ready got %b exp 1", mem_ready); end
    @(negedge clk); drv(1, 3, 32'h18, 0, 2, 0); #1;
    checks++;
    if ({d_req, mem_ready} !== 2'b00) begin
      failures++; $display("FAIL b2b_full req/ready got %b exp 00", {d_req, mem_ready});
    end
    @(negedge clk); #1;
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL b2b_hold ready got %b exp 0", mem_ready); end
    @(negedge clk); bus(1, 1, 32'h1111_1111, 0); #1;
    checks++;
    if ({mem_ready, res_valid, res_id, res_rdata} !== {1'b0, 1'b1, 3'd1, 32'h1111_1111}) begin
      failures++; $display("FAIL b2b_pop1 ready=%b v=%b id=%0d rdata=%h exp ready=0 v=1 id=1 rdata=11111111",
                           mem_ready, res_valid, res_id, res_rdata);
    end
    @(negedge clk); bus(1, 0, 0, 0); #1;
    checks++;
    if ({d_req, mem_ready} !== 2'b11) begin
      failures++; $display("FAIL b2b_id3 req/ready got %b exp 11", {d_req, mem_ready});
    end
    @(negedge clk); drv(0, 0, 0, 0, 0, 0); bus(0, 1, 32'h2222_2222, 0); #1;
    checks++;
    if ({res_valid, res_id} !== {1'b1, 3'd2}) begin
      failures++; $display("FAIL b2b_res2 v=%b id=%0d exp v=1 id=2", res_valid, res_id);
    end
    @(negedge clk); bus(0, 1, 32'h3333_3333, 0); #1;
    checks++;
    if ({res_valid, res_id, res_rdata} !== {1'b1, 3'd3, 32'h3333_3333}) begin
      failures++; $display("FAIL b2b_res3 v=%b id=%0d rdata=%h exp v=1 id=3 rdata=33333333",
                           res_valid, res_id, res_rdata);
    end
    @(negedge clk); bus(0, 0, 0, 0);
  endtask

  task automatic test_bus_error();
    @(negedge clk); drv(1, 6, 32'h20, 0, 2, 0); bus(1, 0, 0, 0);
    @(negedge clk); drv(1, 7, 32'h24, 0, 2, 0);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0); bus(0, 1, 32'hA5A5_A5A5, 0); #1;
    checks++;
    if ({res_valid, res_id, res_err} !== {1'b1, 3'd6, 1'b0}) begin
      failures++; $display("FAIL err_first v=%b id=%0d err=%b exp v=1 id=6 err=0", res_valid, res_id, res_err);
    end
    @(negedge clk); bus(0, 1, 32'h0, 1); #1;
    checks++;
    if ({res_valid, res_id, res_err} !== {1'b1, 3'd7, 1'b1}) begin
      failures++; $display("FAIL err_second v=%b id=%0d err=%b exp v=1 id=7 err=1", res_valid, res_id, res_err);
    end
    @(negedge clk); bus(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drv(1, 2, 32'h30, 0, 2, 0); bus(1, 0, 0, 0);
    @(negedge clk); drv(1, 3, 32'h34, 0, 2, 0);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0); bus(0, 0, 0, 0); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if ({d_req, mem_ready, res_valid} !== 3'b000) begin
      failures++; $display("FAIL rst_mid_idle req/ready/rv got %b exp 000", {d_req, mem_ready, res_valid});
    end
    @(negedge clk); drv(1, 4, 32'h40, 0, 2, 0); bus(1, 0, 0, 0); #1;
    checks++;
    if ({d_req, mem_ready} !== 2'b11) begin
      failures++; $display("FAIL rst_mid_new1 req/ready got %b exp 11", {d_req, mem_ready});
    end
    @(negedge clk); drv(1, 5, 32'h44, 0, 2, 0); #1;
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_new2 ready got %b exp 1", mem_ready); end
    @(negedge clk); drv(1, 6, 32'h48, 0, 2, 0); #1;
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_full ready got %b exp 0", mem_ready); end
    @(negedge clk); drv(0, 0, 0, 0, 0, 0); bus(0, 1, 0, 0); #1;
    checks++;
    if ({res_valid, res_id} !== {1'b1, 3'd4}) begin
      failures++; $display("FAIL rst_mid_res4 v=%b id=%0d exp v=1 id=4", res_valid, res_id);
    end
    @(negedge clk); #1;
    checks++;
    if ({res_valid, res_id} !== {1'b1, 3'd5}) begin
      failures++; $display("FAIL rst_mid_res5 v=%b id=%0d exp v=1 id=5", res_valid, res_id);
    end
    @(negedge clk); bus(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_exceptions();
    test_back_to_back();
    test_bus_error();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
